mult_job_scheduler: RTL and testbench



---
 rtl/mult_sched_pkg.sv | 15 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/mult_job_scheduler.sv | 135 +++++++++++++
 tb/tb_mult_job_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the shift-add multiplier job scheduler.
package mult_sched_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; pointers wrap naturally since DEPTH is a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mult_job_scheduler.sv
// Feeds queued operand pairs to the multiplier controller one job at a time and
// registers each product on an output stream, with a busy-timeout watchdog.
module mult_job_scheduler
    import mult_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mult_start,
    input  logic               mult_ready,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic [2*WIDTH-1:0] mult_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy,
    output logic               err,
    output logic [7:0]         jobs_done
);

    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_nx;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PW-1:0]  fifo_rdata;
    logic           pop;
    logic           capture;
    logic           timeout;
    logic           wd_run;
    logic           slot_free;
    logic [WDW-1:0] wdog;

    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid || out_ready;

    sync_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Waiting on the multiplier is watched; holding for a full output slot is not.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        wd_run   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && mult_ready) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: state_nx = WAIT_LOW;
            WAIT_LOW: begin
                wd_run = 1'b1;
                if (!mult_ready) state_nx = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!mult_ready) begin
                    wd_run = 1'b1;
                end else if (slot_free) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (wd_run && (wdog == WDW'(TIMEOUT - 1))) begin
            timeout  = 1'b1;
            state_nx = IDLE;
        end
    end

    always_comb begin
        mult_start = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE:    busy       = 1'b0;
            START:   mult_start = 1'b1;
            default: busy       = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mult_a    <= '0;
            mult_b    <= '0;
            wdog      <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            jobs_done <= '0;
        end else begin
            if (pop) {mult_a, mult_b} <= fifo_rdata;
            if (pop)         wdog <= '0;
            else if (wd_run) wdog <= wdog + WDW'(1);
            if (timeout) err <= 1'b1;
            if (capture) begin
                out_p     <= mult_p;
                out_valid <= 1'b1;
                jobs_done <= jobs_done + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Directed bench for mult_job_scheduler with a behavioural shift-add multiplier controller.
module tb_mult_job_scheduler;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mult_start;
    logic        mult_ready;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic [15:0] mult_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;
    logic        err;
    logic [7:0]  jobs_done;

    mult_job_scheduler #(.WIDTH(8), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mult_start (mult_start),
        .mult_ready (mult_ready),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_p     (mult_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .busy       (busy),
        .err        (err),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    // Multiplier controller model: ready drops one cycle after start, stays low 10 cycles.
    logic        m_ready   = 1'b1;
    logic [15:0] m_p       = '0;
    int          m_st      = 0;
    int          m_cnt     = 0;
    bit          hang      = 1'b0;
    bit          hold_busy = 1'b0;

    assign mult_ready = m_ready && !hold_busy;
    assign mult_p     = m_p;

    always @(posedge clk) begin
        case (m_st)
            0: if (mult_start) m_st <= 1;
            1: begin m_ready <= 1'b0; m_cnt <= 9; m_st <= 2; end
            default: begin
                if (!hang) begin
                    if (m_cnt == 0) begin
                        m_ready <= 1'b1;
                        m_p     <= 16'(mult_a) * 16'(mult_b);
                        m_st    <= 0;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            end
        endcase
    end

    int          cyc = 0;
    int          n_starts = 0;
    int          last_start_cyc = 0;
    int          bad_start = 0;
    logic [15:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mult_start) begin
            n_starts       <= n_starts + 1;
            last_start_cyc <= cyc;
            if (!mult_ready) bad_start <= bad_start + 1;
        end
        if (rst_n && out_valid && out_ready) got.push_back(out_p);
    end

    int n_vec = 0;
    int n_err = 0;
    int acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int k;
        in_a = a; in_b = b; in_valid = 1'b1; k = 0;
        while (!in_ready && k < 500) begin step(); k++; end
        check("push_accept", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_out(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 200) begin step(); k++; end
        check(name, 32'(out_valid), 1);
    endtask

    task automatic wait_got(input int n, input int bound);
        int k;
        k = 0;
        while (got.size() < n && k < bound) begin step(); k++; end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int base_j;
        int base_s;
        int err_cyc;
        int k;
        logic rdy;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd1,   8'd1,   16'd1};
        vecs[4] = '{8'd128, 8'd2,   16'd256};
        vecs[5] = '{8'd17,  8'd15,  16'd255};
        vecs[6] = '{8'd200, 8'd100, 16'd20000};
        vecs[7] = '{8'd255, 8'd1,   16'd255};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready",   32'(in_ready), 1);
        check("rst_mult_start", 32'(mult_start), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_out_valid",  32'(out_valid), 0);
        check("rst_err",        32'(err), 0);
        check("rst_jobs_done",  32'(jobs_done), 0);
        rst_n = 1'b1;
        step();

        // Single jobs from the table, each held under backpressure before draining.
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            base_j = int'(jobs_done);
            base_s = n_starts;
            push(vecs[i].a, vecs[i].b);
            wait_out($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_p", i), 32'(out_p), 32'(vecs[i].p));
            if (i == 0) begin
                check("accept_to_start", 32'(last_start_cyc - acc_cyc), 1);
                check("start_to_valid",  32'(cyc - last_start_cyc), 13);
            end
            repeat (3) step();
            check($sformatf("vec%0d_held", i), 32'({out_valid, out_p}), 32'({1'b1, vecs[i].p}));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("vec%0d_drop", i), 32'(out_valid), 0);
            check($sformatf("vec%0d_jobs", i), 32'(jobs_done), 32'(8'(base_j + 1)));
            check($sformatf("vec%0d_starts", i), 32'(n_starts - base_s), 1);
        end

        // FIFO fill while the multiplier reports busy.
        hold_busy = 1'b1; out_ready = 1'b1; got.delete(); base_j = int'(jobs_done);
        for (int i = 1; i <= 5; i++) begin
            in_a = 8'(i); in_b = 8'(i); in_valid = 1'b1;
            rdy = in_ready;
            step();
            check($sformatf("fill_ready_%0d", i), 32'(rdy), (i <= 4) ? 1 : 0);
        end
        in_valid = 1'b0;
        check("fill_full", 32'(in_ready), 0);
        check("fill_idle", 32'(busy), 0);
        hold_busy = 1'b0;
        wait_got(4, 400);
        repeat (20) step();
        check("fill_count", 32'(got.size()), 4);
        for (int j = 0; j < 4; j++)
            check($sformatf("fill_p%0d", j), (got.size() > j) ? 32'(got[j]) : 32'hFFFF_FFFF, 32'((j + 1) * (j + 1)));
        check("fill_ready_back", 32'(in_ready), 1);
        check("fill_jobs", 32'(jobs_done), 32'(8'(base_j + 4)));

        // Output backpressure with two jobs queued.
        out_ready = 1'b0; got.delete(); base_j = int'(jobs_done); base_s = n_starts;
        push(8'd6, 8'd7);
        push(8'd8, 8'd9);
        wait_out("bp_valid");
        check("bp_first_p", 32'(out_p), 42);
        repeat (30) step();
        check("bp_held", 32'({out_valid, out_p}), 32'({1'b1, 16'd42}));
        check("bp_jobs_held", 32'(jobs_done), 32'(8'(base_j + 1)));
        check("bp_no_err", 32'(err), 0);
        out_ready = 1'b1;
        wait_got(2, 200);
        repeat (20) step();
        check("bp_count", 32'(got.size()), 2);
        check("bp_p0", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 42);
        check("bp_p1", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF, 72);
        check("bp_jobs", 32'(jobs_done), 32'(8'(base_j + 2)));
        check("bp_starts", 32'(n_starts - base_s), 2);

        // Watchdog: the multiplier never comes back.
        hang = 1'b1; got.delete(); base_j = int'(jobs_done); base_s = n_starts;
        push(8'd7, 8'd9);
        k = 0;
        while (!err && k < 200) begin step(); k++; end
        err_cyc = cyc;
        check("to_err", 32'(err), 1);
        check("to_latency", 32'(err_cyc - last_start_cyc), 32'(TIMEOUT + 1));
        check("to_no_out", 32'(got.size()), 0);
        check("to_jobs", 32'(jobs_done), 32'(base_j));
        check("to_idle", 32'(busy), 0);
        hang = 1'b0;
        push(8'd5, 8'd6);
        wait_out("to_next_valid");
        check("to_next_p", 32'(out_p), 30);
        step();
        check("to_err_sticky", 32'(err), 1);
        check("to_next_jobs", 32'(jobs_done), 32'(8'(base_j + 1)));

        // Reset in the middle of a job.
        base_s = n_starts;
        push(8'd3, 8'd5);
        k = 0;
        while (n_starts == base_s && k < 100) begin step(); k++; end
        repeat (5) step();
        check("mid_busy", 32'({busy, mult_ready}), 32'(2'b10));
        rst_n = 1'b0;
        step();
        check("mid_rst_in_ready",   32'(in_ready), 1);
        check("mid_rst_mult_start", 32'(mult_start), 0);
        check("mid_rst_mult_ab",    32'({mult_a, mult_b}), 0);
        check("mid_rst_out",        32'({out_valid, out_p}), 0);
        check("mid_rst_busy",       32'(busy), 0);
        check("mid_rst_err",        32'(err), 0);
        check("mid_rst_jobs",       32'(jobs_done), 0);
        rst_n = 1'b1;
        got.delete(); base_s = n_starts;
        push(8'd2, 8'd2);
        wait_out("post_rst_valid");
        check("post_rst_p", 32'(out_p), 4);
        check("post_rst_starts", 32'(n_starts - base_s), 1);

        // 256 jobs wrap the completed-job counter.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("wrap_start", 32'(jobs_done), 0);
        out_ready = 1'b1; got.delete();
        for (int i = 0; i < 255; i++) push(8'(i), 8'(255 - i));
        wait_got(255, 8000);
        step();
        check("wrap_255", 32'(jobs_done), 255);
        push(8'd255, 8'd255);
        wait_got(256, 200);
        step();
        check("wrap_0", 32'(jobs_done), 0);
        check("wrap_count", 32'(got.size()), 256);
        check("wrap_p100", (got.size() > 100) ? 32'(got[100]) : 32'hFFFF_FFFF, 15500);
        check("wrap_p255", (got.size() > 255) ? 32'(got[255]) : 32'hFFFF_FFFF, 65025);

        check("start_while_busy", 32'(bad_start), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
